chroma_decimator: RTL

- Encoder-side counterpart of the chroma interpolation FIR: takes one full-resolution (4:4:4) U or V line and low-pass filters it with a 7-tap half-band filter.
- Decimates by 2 to 4:2:2 and packs result pairs into 16-bit SRAM words: earlier sample in [15:8], later in [7:0].
- The top level instantiates one per chroma channel between the colour-space converter and the SRAM write arbiter.

---
 rtl/chroma_decimator.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/chroma_decimator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : chroma_decimator                                                 |
// | Purpose : 7-tap half-band low-pass filter and 2:1 decimation of one 4:4:4  |
// |           chroma line to 4:2:2. Result bytes are packed in pairs into      |
// |           16-bit words: earlier byte in [15:8], later byte in [7:0].       |
// | Option  : define CHROMA_DEC_SAT_CNT_EN to count clipped results in         |
// |           sat_count; otherwise sat_count is tied to zero.                  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module chroma_decimator #(
  parameter int C1    = 81,
  parameter int C3    = 17,
  parameter int ACC_W = 18
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_first,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        line_done,
  output logic        busy,
  output logic [15:0] sat_count
);

  localparam logic signed [ACC_W-1:0] C_CENTRE = ACC_W'(128);
  localparam logic signed [ACC_W-1:0] C_ROUND  = ACC_W'(128);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_FILL  = 4'd1,
    ST_RUN   = 4'd2,
    ST_MAC0  = 4'd3,
    ST_MAC1  = 4'd4,
    ST_MAC2  = 4'd5,
    ST_PUSH  = 4'd6,
    ST_FLUSH = 4'd7,
    ST_DONE  = 4'd8
  } state_t;

  state_t                  r_state;
  logic [7:0]              r_sh [0:6];    // r_sh[0] newest, r_sh[3] centre
  logic [1:0]              r_cnt;         // shifts still needed before next centre
  logic                    r_flushing;    // in_last seen for this line
  logic [1:0]              r_fl_shifts;   // replicated shifts done at right edge
  logic                    r_final;       // current compute is the last of the line
  logic signed [ACC_W-1:0] r_acc;
  logic [7:0]              r_res;
  logic [7:0]              r_hi;
  logic                    r_hi_pend;

  logic                    w_xfer;
  logic [8:0]              w_pair;
  logic signed [ACC_W-1:0] w_coef;
  logic signed [ACC_W-1:0] w_opnd;
  logic signed [ACC_W-1:0] w_prod;
  logic signed [ACC_W-1:0] w_acc_fin;
  logic signed [ACC_W-1:0] w_shr;
  logic                    w_lo_clip;
  logic                    w_hi_clip;
  logic [7:0]              w_clip;
  logic                    w_complete;
  logic                    w_stall;
  logic [15:0]             w_word;

  assign w_xfer = in_valid & in_ready;

  // Shared multiplier operand/coefficient select: centre, +-1 pair, +-3 pair
  always_comb begin
    w_pair = {1'b0, r_sh[3]};
    w_coef = C_CENTRE;
    case (r_state)
      ST_MAC1: begin
        w_pair = {1'b0, r_sh[2]} + {1'b0, r_sh[4]};
        w_coef = ACC_W'(C1);
      end
      ST_MAC2: begin
        w_pair = {1'b0, r_sh[0]} + {1'b0, r_sh[6]};
        w_coef = ACC_W'(-C3);
      end
      default: ;
    endcase
  end

  assign w_opnd    = signed'({{(ACC_W-9){1'b0}}, w_pair});
  assign w_prod    = w_coef * w_opnd;
  assign w_acc_fin = r_acc + w_prod;
  assign w_shr     = w_acc_fin >>> 8;
  assign w_lo_clip = w_shr[ACC_W-1];
  assign w_hi_clip = ~w_shr[ACC_W-1] & (|w_shr[ACC_W-2:8]);

  // Clip the scaled sum to the 8-bit sample range
  always_comb begin
    w_clip = w_shr[7:0];
    if (w_lo_clip)      w_clip = 8'd0;
    else if (w_hi_clip) w_clip = 8'd255;
  end

  // A word completes on the second byte, or on a lone last byte (replicated)
  assign w_complete = r_hi_pend | r_final;
  assign w_word     = r_hi_pend ? {r_hi, r_res} : {r_res, r_res};
  assign w_stall    = w_complete & word_valid & ~word_ready;

  // Line sequencing FSM, shift register, accumulator and output word register
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      for (int i = 0; i < 7; i++) r_sh[i] <= 8'd0;
      r_cnt       <= 2'd0;
      r_flushing  <= 1'b0;
      r_fl_shifts <= 2'd0;
      r_final     <= 1'b0;
      r_acc       <= '0;
      r_res       <= 8'd0;
      r_hi        <= 8'd0;
      r_hi_pend   <= 1'b0;
      in_ready    <= 1'b1;
      word_out    <= 16'd0;
      word_valid  <= 1'b0;
      line_done   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      line_done <= 1'b0;
      if (word_valid && word_ready) word_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_xfer && in_first) begin
            // left-edge replication: x0 fills every tap
            for (int i = 0; i < 7; i++) r_sh[i] <= in_data;
            busy        <= 1'b1;
            r_cnt       <= 2'd3;
            r_flushing  <= 1'b0;
            r_fl_shifts <= 2'd0;
            r_hi_pend   <= 1'b0;
            r_final     <= 1'b0;
            r_state     <= ST_FILL;
          end
        end

        ST_FILL, ST_RUN: begin
          if (w_xfer) begin
            r_sh[0] <= in_data;
            for (int i = 1; i < 7; i++) r_sh[i] <= r_sh[i-1];
            r_cnt <= r_cnt - 2'd1;
            if (in_last) r_flushing <= 1'b1;
            if (r_cnt == 2'd1) begin
              r_final  <= 1'b0;
              in_ready <= 1'b0;
              r_state  <= ST_MAC0;
            end else if (in_last) begin
              in_ready <= 1'b0;
              r_state  <= ST_FLUSH;
            end
          end
        end

        ST_MAC0: begin
          r_acc   <= w_prod + C_ROUND;
          r_cnt   <= 2'd2;
          r_state <= ST_MAC1;
        end

        ST_MAC1: begin
          r_acc   <= w_acc_fin;
          r_state <= ST_MAC2;
        end

        ST_MAC2: begin
          r_res   <= w_clip;
          r_state <= ST_PUSH;
        end

        ST_PUSH: begin
          if (!w_complete) begin
            r_hi      <= r_res;
            r_hi_pend <= 1'b1;
            in_ready  <= ~r_flushing;
            r_state   <= r_flushing ? ST_FLUSH : ST_RUN;
          end else if (!w_stall) begin
            word_out   <= w_word;
            word_valid <= 1'b1;
            r_hi_pend  <= 1'b0;
            if (r_final) begin
              r_state <= ST_DONE;
            end else begin
              in_ready <= ~r_flushing;
              r_state  <= r_flushing ? ST_FLUSH : ST_RUN;
            end
          end
        end

        ST_FLUSH: begin
          // right-edge replication: the newest sample is repeated
          for (int i = 1; i < 7; i++) r_sh[i] <= r_sh[i-1];
          r_cnt       <= r_cnt - 2'd1;
          r_fl_shifts <= r_fl_shifts + 2'd1;
          if (r_cnt == 2'd1) begin
            // the compute after the second replicated shift is the last centre
            r_final <= (r_fl_shifts != 2'd0);
            r_state <= ST_MAC0;
          end
        end

        ST_DONE: begin
          if (word_valid && word_ready) begin
            line_done <= 1'b1;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end

        default: begin
          in_ready <= 1'b1;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CHROMA_DEC_SAT_CNT_EN
  logic w_sat;
  assign w_sat = w_lo_clip | w_hi_clip;

  // Saturating count of clipped results, cleared at the start of each line
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      sat_count <= 16'd0;
    end else if (r_state == ST_IDLE && w_xfer && in_first) begin
      sat_count <= 16'd0;
    end else if (r_state == ST_MAC2 && w_sat && sat_count != 16'hFFFF) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`else
  assign sat_count = 16'd0;
`endif

endmodule
`default_nettype wire
